approx_adder_arbiter: RTL and testbench

Shares one 8-bit lower-part-OR approximate adder between `N_REQ` requesters using round-robin arbitration and valid/ready handshakes. Each accepted operand pair is added by the embedded approximate datapath. The result is held in a single registered output slot, tagged with the requester index, until the consumer takes it. It sits between operand-producing engines and a shared result sink, and replaces per-requester adder instances.

---
 rtl/approx_adder_arbiter.sv | 138 +++++++++++++
 tb/tb_approx_adder_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_arbiter.sv
// approx_adder_arbiter: round-robin sharing of one 8-bit lower-part-OR
// approximate adder between N_REQ requesters, with a single registered
// result slot tagged by requester index and a saturating op counter.
module approx_adder_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned P_APPROX = 1,
    parameter int unsigned ID_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          ops_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    slot_state_t          r_state;
    slot_state_t          w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [SUM_W-1:0]     r_rsp_data;
    logic [ID_W-1:0]      r_rsp_id;
    logic [CNT_W-1:0]     r_ops_count;

    logic                 w_can_accept;
    logic                 w_xfer;
    logic [ID_W-1:0]      w_gnt_idx;
    int unsigned          w_scan;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [SUM_W-1:0]     w_sum;

    // Lower P_APPROX bits are ORed; the top of that region seeds an exact upper adder.
    function automatic logic [SUM_W-1:0] approx_add(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [SUM_W-1:0] y;
        logic             c;
        y = '0;
        c = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i < int'(P_APPROX)) begin
                y[i] = a[i] | b[i];
                c    = a[i] & b[i];
            end else begin
                y[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | ((a[i] | b[i]) & c);
            end
        end
        y[DATA_W] = c;
        return y;
    endfunction

    // Round-robin search from r_rr_ptr; grants only when the slot can take a result.
    always_comb begin
        w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
        w_xfer       = 1'b0;
        w_gnt_idx    = '0;
        w_scan       = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_scan = (32'(r_rr_ptr) + 32'(k)) % N_REQ;
            if (!w_xfer && rst_n && w_can_accept && req_valid[ID_W'(w_scan)]) begin
                w_xfer    = 1'b1;
                w_gnt_idx = ID_W'(w_scan);
            end
        end
    end

    // One-hot ready on the granted requester, zero otherwise.
    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Operand mux into the shared approximate adder.
    always_comb begin
        w_a   = req_a[DATA_W*int'(w_gnt_idx) +: DATA_W];
        w_b   = req_b[DATA_W*int'(w_gnt_idx) +: DATA_W];
        w_sum = approx_add(w_a, w_b);
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: a transfer fills it, a drain without a transfer empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && rsp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Result payload, round-robin pointer and saturating op counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
            r_ops_count <= '0;
        end else if (w_xfer) begin
            r_rsp_data <= w_sum;
            r_rsp_id   <= w_gnt_idx;
            r_rr_ptr   <= ID_W'((32'(w_gnt_idx) + 32'd1) % N_REQ);
            if (r_ops_count != CNT_MAX) begin
                r_ops_count <= r_ops_count + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_count = r_ops_count;

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Directed bench for approx_adder_arbiter: an approximate (P_APPROX=1) and an
// exact (P_APPROX=0) instance share the same requester/consumer stimulus.
module tb_approx_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [8:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] ops_count;

    logic [3:0]  x_req_ready;
    logic        x_rsp_valid;
    logic [8:0]  x_rsp_data;
    logic [1:0]  x_rsp_id;
    logic [15:0] x_ops_count;

    int n_vec = 0;
    int n_err = 0;

    approx_adder_arbiter #(.N_REQ(4), .P_APPROX(1), .ID_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .ops_count(ops_count)
    );

    approx_adder_arbiter #(.N_REQ(4), .P_APPROX(0), .ID_W(2)) u_exact (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(x_req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(x_rsp_data), .rsp_id(x_rsp_id), .ops_count(x_ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset values with every requester asking
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_ops", 32'(ops_count), 32'h0);

        // Approximate sums, requester 2 alone
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_op(2, 8'h0F, 8'h01);
        #1;
        chk("sum1_ready", 32'(req_ready), 32'h4);
        step();
        chk("sum1_valid", 32'(rsp_valid), 32'h1);
        chk("sum1_data", 32'(rsp_data), 32'h011);
        chk("sum1_id", 32'(rsp_id), 32'h2);
        chk("sum1_exact", 32'(x_rsp_data), 32'h010);

        set_op(2, 8'hFF, 8'h01);
        #1;
        chk("sum2_ready", 32'(req_ready), 32'h4);
        step();
        chk("sum2_data", 32'(rsp_data), 32'h101);
        chk("sum2_id", 32'(rsp_id), 32'h2);

        set_op(2, 8'h80, 8'h80);
        step();
        chk("sum3_data", 32'(rsp_data), 32'h100);

        set_op(2, 8'hFF, 8'hFF);
        step();
        chk("sum4_data", 32'(rsp_data), 32'h1FF);
        chk("sum4_exact", 32'(x_rsp_data), 32'h1FE);
        chk("sum_ops", 32'(ops_count), 32'd4);

        // Drain with no request: slot empties, payload holds
        req_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_hold", 32'(rsp_data), 32'h1FF);

        // Round-robin from reset: grants 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h20 * (i + 1)), 8'h01);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_data", 32'(rsp_data), 32'(9'h021 + 9'(9'h020 * (k % 4))));
        end
        chk("rr_ops", 32'(ops_count), 32'd5);

        // Backpressure: slot holds requester 0 result, pointer at 1
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_data", 32'(rsp_data), 32'h021);
            step();
        end
        chk("bp_data_end", 32'(rsp_data), 32'h021);
        chk("bp_ops", 32'(ops_count), 32'd5);

        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        step();
        chk("bp_reload_valid", 32'(rsp_valid), 32'h1);
        chk("bp_reload_id", 32'(rsp_id), 32'h1);
        chk("bp_reload_data", 32'(rsp_data), 32'h041);
        chk("bp_reload_ops", 32'(ops_count), 32'd6);

        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        step();
        chk("bp_wait_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        step();
        chk("bp_empty_valid", 32'(rsp_valid), 32'h0);

        // Reset while FULL discards the result and restarts the pointer
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        step();
        chk("rf_full", 32'(rsp_valid), 32'h1);
        chk("rf_id", 32'(rsp_id), 32'h2);
        rst_n = 1'b0;
        step();
        chk("rf_valid", 32'(rsp_valid), 32'h0);
        chk("rf_ops", 32'(ops_count), 32'h0);
        rst_n     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("rf_ptr", 32'(req_ready), 32'h1);
        step();
        chk("rf_id0", 32'(rsp_id), 32'h0);

        // Counter saturation: reach 0xFFFE, then three more transfers
        for (int c = 0; c < 70000 && ops_count != 16'hFFFE; c++) step();
        chk("sat_reach", 32'(ops_count), 32'hFFFE);
        step();
        chk("sat_max", 32'(ops_count), 32'hFFFF);
        step();
        step();
        chk("sat_hold", 32'(ops_count), 32'hFFFF);
        chk("sat_valid", 32'(rsp_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
